icmp_echo_buffer: RTL

Parametrised successor to the fixed 256-word ping payload store. It captures one ICMP echo-request frame as 32-bit words (ICMP header first), zero-masks the trailing partial word, and computes the echo-reply one's-complement checksum. It then streams the reply out over a valid/ready handshake, with header word 0 rewritten to {type 0, code, checksum}. It sits between the IPv4 RX parser and the TX frame builder.

---
 rtl/icmp_pkg.sv | 29 ++
 rtl/csum16_acc.sv | 48 ++++
 rtl/icmp_echo_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/icmp_pkg.sv
// icmp_pkg: shared ICMP type codes, buffer state encoding and the
// last-word byte mask used by icmp_echo_buffer.
package icmp_pkg;

    localparam logic [7:0] ICMP_ECHO_REQUEST = 8'd8;
    localparam logic [7:0] ICMP_ECHO_REPLY   = 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DISCARD,
        FOLD1,
        FOLD2,
        SEND
    } state_t;

    // Keep the first last_bytes bytes (big-endian); 0 means all four
    function automatic logic [31:0] byte_mask(input logic [1:0] last_bytes);
        logic [31:0] m;
        case (last_bytes)
            2'd1:    m = 32'hFF00_0000;
            2'd2:    m = 32'hFFFF_0000;
            2'd3:    m = 32'hFFFF_FF00;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/csum16_acc.sv
// csum16_acc: one's-complement accumulator. Sums the two 16-bit halves of
// each word into a wide accumulator, then folds it in two registered stages.
module csum16_acc #(
    parameter int ACC_W = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        add,
    input  logic [31:0] word,
    input  logic        fold1,
    input  logic        fold2,
    output logic [15:0] fold_now,
    output logic [15:0] sum
);

    logic [ACC_W-1:0] acc;
    logic [16:0]      halves;
    logic [16:0]      s1;
    logic [16:0]      s1_nxt;

    // Half-word sum of the incoming word and first fold of the accumulator
    always_comb begin
        halves   = {1'b0, word[31:16]} + {1'b0, word[15:0]};
        s1_nxt   = {1'b0, acc[15:0]} + 17'(acc[ACC_W-1:16]);
        fold_now = s1[15:0] + {15'd0, s1[16]};
    end

    // Accumulate on each stored word, then register both fold stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            s1  <= '0;
            sum <= '0;
        end else begin
            if (add) begin
                acc <= load ? ACC_W'(halves) : acc + ACC_W'(halves);
            end
            if (fold1) begin
                s1 <= s1_nxt;
            end
            if (fold2) begin
                sum <= fold_now;
            end
        end
    end

endmodule

// File: rtl/icmp_echo_buffer.sv
// icmp_echo_buffer: captures one ICMP echo-request frame, computes the
// echo-reply checksum and streams the reply on a valid/ready port with
// header word 0 rewritten to {type 0, code, checksum}.
// Build option: define ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN to check the received
// checksum and drop failing frames (adds the o_cksum_err port).
module icmp_echo_buffer #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = ADDR_W + 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_wren,
    input  logic [31:0]      i_data,
    input  logic             i_last,
    input  logic [1:0]       i_last_bytes,
    output logic             o_busy,
    output logic             o_drop,
    output logic             o_overflow,
    output logic [LEN_W-1:0] o_len_bytes,
    output logic [31:0]      o_data,
    output logic             o_valid,
    output logic             o_last,
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
    output logic             o_cksum_err,
`endif
    input  logic             i_ready
);

    import icmp_pkg::*;

    localparam int DEPTH = 1 << ADDR_W;
    localparam int ACC_W = 16 + ADDR_W + 1;

    localparam logic [ADDR_W:0]   WR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] RD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        last_bytes_q;
    logic [ADDR_W+2:0] len_full;
    logic [31:0]       wdata;
    logic [31:0]       main_word;
    logic              take_start;
    logic              take_word;
    logic              ovf_hit;
    logic              drop_hit;
    logic              fold1;
    logic              fold2;
    logic              fire;
    logic [15:0]       main_sum;
    logic [15:0]       main_fold_unused;
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
    logic              cksum_bad;
    logic [15:0]       vfy_fold;
    logic [15:0]       vfy_sum_unused;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle write/fold/pulse strobes
    always_comb begin
        state_nxt  = state;
        take_start = 1'b0;
        take_word  = 1'b0;
        ovf_hit    = 1'b0;
        drop_hit   = 1'b0;
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
        cksum_bad  = 1'b0;
`endif
        case (state)
            IDLE, DISCARD: begin
                if (i_wren && i_start) begin
                    take_start = 1'b1;
                    state_nxt  = i_last ? FOLD1 : FILL;
                end else if (state == DISCARD && i_wren && i_last) begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if (i_wren) begin
                    if (i_start) begin
                        take_start = 1'b1;
                        state_nxt  = i_last ? FOLD1 : FILL;
                    end else if (wr_ptr[ADDR_W]) begin
                        ovf_hit   = 1'b1;
                        state_nxt = i_last ? IDLE : DISCARD;
                    end else begin
                        take_word = 1'b1;
                        if (i_last) begin
                            state_nxt = FOLD1;
                        end
                    end
                end
            end
            FOLD1: begin
                drop_hit  = i_wren && i_start;
                state_nxt = FOLD2;
            end
            FOLD2: begin
                drop_hit = i_wren && i_start;
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
                if (vfy_fold != 16'hFFFF) begin
                    cksum_bad = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = SEND;
                end
`else
                state_nxt = SEND;
`endif
            end
            SEND: begin
                drop_hit = i_wren && i_start;
                if (fire && o_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Masked write data, checksum contribution and reply-side outputs
    always_comb begin
        wdata     = i_last ? (i_data & byte_mask(i_last_bytes)) : i_data;
        // Word 0 counts only its code byte: type reads as 0, checksum field as 0
        main_word = take_start ? {24'h0, wdata[23:16]} : wdata;
        fold1     = (state == FOLD1);
        fold2     = (state == FOLD2);
        o_valid   = (state == SEND);
        o_busy    = (state == FOLD1) || (state == FOLD2) || (state == SEND);
        fire      = o_valid && i_ready;
        o_last    = o_valid && ({1'b0, rd_ptr} == (wr_ptr - WR_ONE));
        o_data    = (rd_ptr == '0) ? {ICMP_ECHO_REPLY, mem[0][23:16], ~main_sum}
                                   : mem[rd_ptr];
        // A full DEPTH-word frame ending in 4 bytes wraps at the default LEN_W
        len_full  = {wr_ptr - WR_ONE, 2'b00}
                  + ((last_bytes_q == 2'd0) ? {{ADDR_W{1'b0}}, 3'd4}
                                            : {{(ADDR_W+1){1'b0}}, last_bytes_q});
    end

    // Payload store, asynchronous read
    always_ff @(posedge clk) begin
        if (take_start) begin
            mem[0] <= wdata;
        end else if (take_word) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wdata;
        end
    end

    // Pointers, reply length and single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            last_bytes_q <= '0;
            o_len_bytes  <= '0;
            o_drop       <= 1'b0;
            o_overflow   <= 1'b0;
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
            o_cksum_err  <= 1'b0;
`endif
        end else begin
            o_drop     <= drop_hit;
            o_overflow <= ovf_hit;
`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
            o_cksum_err <= cksum_bad;
`endif
            if (take_start) begin
                wr_ptr       <= WR_ONE;
                last_bytes_q <= i_last_bytes;
            end else if (take_word) begin
                wr_ptr       <= wr_ptr + WR_ONE;
                last_bytes_q <= i_last_bytes;
            end
            if (fold1) begin
                o_len_bytes <= LEN_W'(len_full);
            end
            if (state != SEND) begin
                rd_ptr <= '0;
            end else if (i_ready) begin
                rd_ptr <= rd_ptr + RD_ONE;
            end
        end
    end

    csum16_acc #(
        .ACC_W(ACC_W)
    ) u_main_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take_start),
        .add      (take_start | take_word),
        .word     (main_word),
        .fold1    (fold1),
        .fold2    (fold2),
        .fold_now (main_fold_unused),
        .sum      (main_sum)
    );

`ifdef ICMP_ECHO_BUFFER_CKSUM_VERIFY_EN
    csum16_acc #(
        .ACC_W(ACC_W)
    ) u_verify_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (take_start),
        .add      (take_start | take_word),
        .word     (wdata),
        .fold1    (fold1),
        .fold2    (fold2),
        .fold_now (vfy_fold),
        .sum      (vfy_sum_unused)
    );
`endif

endmodule
